// File: rtl/md_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: MD opcode
// encoding, default latencies and small opcode-class helpers.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic logic md_is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath of the MD unit: 64-bit signed/unsigned products and
// quotient/remainder, presented as the {hi, lo} pair the operation will commit.
module md_arith
  import md_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  logic signed [63:0] prodSigned;
  logic        [63:0] prodUnsigned;
  logic               signedDiv;
  logic               negA;
  logic               negB;
  logic        [31:0] magA;
  logic        [31:0] magB;
  logic        [31:0] uQuot;
  logic        [31:0] uRem;
  logic        [31:0] quot;
  logic        [31:0] rem;

  assign prodSigned   = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prodUnsigned = {32'd0, a_i} * {32'd0, b_i};
  assign div_zero_o   = md_is_div(op_i) && (b_i == 32'd0);

  // Signed division runs on magnitudes, so the most negative dividend never
  // hits the host's signed-overflow corner; signs are reapplied afterwards.
  always_comb begin
    signedDiv = (op_i == MD_DIV);
    negA      = signedDiv && a_i[31];
    negB      = signedDiv && b_i[31];
    magA      = negA ? (~a_i + 32'd1) : a_i;
    magB      = negB ? (~b_i + 32'd1) : b_i;
    uQuot     = 32'd0;
    uRem      = 32'd0;
    if (magB != 32'd0) begin
      uQuot = magA / magB;
      uRem  = magA % magB;
    end
    quot = (negA ^ negB) ? (~uQuot + 32'd1) : uQuot;
    rem  = negA ? (~uRem + 32'd1) : uRem;
  end

  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    if (op_i == MD_MULT) begin
      hi_o = prodSigned[63:32];
      lo_o = prodSigned[31:0];
    end else if (op_i == MD_MULTU) begin
      hi_o = prodUnsigned[63:32];
      lo_o = prodUnsigned[31:0];
    end else if (md_is_div(op_i)) begin
      hi_o = rem;
      lo_o = quot;
    end
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, models operation latency with a
// busy counter, and serves mfhi/mflo reads to the EX result mux.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  E_MDop,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_start,
  output logic        E_busy,
  output logic [31:0] E_MD_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] arithHi;
  logic [31:0] arithLo;
  logic        divZero;

  md_arith u_arith (
    .op_i       (E_MDop),
    .a_i        (E_A),
    .b_i        (E_B),
    .hi_o       (arithHi),
    .lo_o       (arithLo),
    .div_zero_o (divZero)
  );

  assign E_busy  = (cnt_q != 4'd0);
  assign E_start = md_is_arith(E_MDop) && !E_busy && !req;
  assign HI      = hi_q;
  assign LO      = lo_q;

  // A divide by zero latches the current HI/LO as its pending result, so the
  // completion write is a no-op while the busy window still runs its length.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    if (E_start) begin
      cnt_d = md_is_div(E_MDop) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      if (divZero) begin
        pend_hi_d = hi_q;
        pend_lo_d = lo_q;
      end else begin
        pend_hi_d = arithHi;
        pend_lo_d = arithLo;
      end
    end else if (E_busy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (!req) begin
      if (E_MDop == MD_MTHI) hi_d = E_A;
      if (E_MDop == MD_MTLO) lo_d = E_A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      cnt_q     <= 4'd0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    E_MD_out = 32'd0;
    if (E_MDop == MD_MFHI) E_MD_out = hi_q;
    else if (E_MDop == MD_MFLO) E_MD_out = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a table of operations with hand-computed HI/LO
// and busy lengths, followed by hand-written flush/overlap/reset sequences.
module tb_md_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam int BUSY_LIMIT = 50;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expBusy;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        req;
  logic [3:0]  E_MDop;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_start;
  logic        E_busy;
  logic [31:0] E_MD_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int total;
  int bad;
  vec_t vecs[12];

  md_unit dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .E_MDop   (E_MDop),
    .E_A      (E_A),
    .E_B      (E_B),
    .E_start  (E_start),
    .E_busy   (E_busy),
    .E_MD_out (E_MD_out),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic syncCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic r);
    E_MDop = op;
    E_A    = a;
    E_B    = b;
    req    = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (E_busy && n < BUSY_LIMIT) begin
      syncCycle();
      n++;
    end
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{OP_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[5]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[6]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[7]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    vecs[8]  = '{OP_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'h00000001, 0};
    vecs[9]  = '{OP_MTLO,  32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
    vecs[10] = '{OP_DIV,   32'h80000000, 32'd2,        32'h00000000, 32'hC0000000, 10};
    vecs[11] = '{OP_NONE,  32'd5,        32'd5,        32'h00000000, 32'hC0000000, 0};

    reset = 1'b1;
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    syncCycle();
    syncCycle();
    reset = 1'b0;
    checkOutput("reset_busy", {31'd0, E_busy}, 32'd0);
    checkOutput("reset_hi", HI, 32'd0);
    checkOutput("reset_lo", LO, 32'd0);
    applyStimulus(OP_MFHI, 32'd0, 32'd0, 1'b0);
    #1 checkOutput("reset_mfhi", E_MD_out, 32'd0);
    applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b0);
    #1 checkOutput("reset_mflo", E_MD_out, 32'd0);

    // Each vector launches in the first idle cycle after the previous one.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      #1 checkOutput($sformatf("vec%0d_start", i), {31'd0, E_start},
                     {31'd0, (vecs[i].expBusy > 0)});
      syncCycle();
      applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
      countBusy(n);
      checkOutput($sformatf("vec%0d_busy_len", i), n, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d_hi", i), HI, vecs[i].expHi);
      checkOutput($sformatf("vec%0d_lo", i), LO, vecs[i].expLo);
      applyStimulus(OP_MFHI, 32'd0, 32'd0, 1'b0);
      #1 checkOutput($sformatf("vec%0d_mfhi", i), E_MD_out, vecs[i].expHi);
      applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b0);
      #1 checkOutput($sformatf("vec%0d_mflo", i), E_MD_out, vecs[i].expLo);
      applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
      #1 checkOutput($sformatf("vec%0d_none_out", i), E_MD_out, 32'd0);
    end

    // Flush in the same cycle as a mult or mthi: nothing launches or writes.
    applyStimulus(OP_MULT, 32'd5, 32'd7, 1'b1);
    #1 checkOutput("req_mult_start", {31'd0, E_start}, 32'd0);
    syncCycle();
    checkOutput("req_mult_busy", {31'd0, E_busy}, 32'd0);
    checkOutput("req_mult_hi", HI, 32'd0);
    checkOutput("req_mult_lo", LO, 32'hC0000000);
    applyStimulus(OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b1);
    syncCycle();
    checkOutput("req_mthi_hi", HI, 32'd0);

    // Flush during a running mult: the older operation still completes at t+6.
    applyStimulus(OP_MULT, 32'd5, 32'd7, 1'b0);
    #1 checkOutput("flush_mid_start", {31'd0, E_start}, 32'd1);
    syncCycle();
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    checkOutput("flush_mid_busy_t1", {31'd0, E_busy}, 32'd1);
    checkOutput("flush_mid_lo_t1", LO, 32'hC0000000);
    syncCycle();
    applyStimulus(OP_MTLO, 32'd1, 32'd0, 1'b1);
    syncCycle();
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    syncCycle();
    syncCycle();
    checkOutput("flush_mid_busy_t5", {31'd0, E_busy}, 32'd1);
    checkOutput("flush_mid_lo_t5", LO, 32'hC0000000);
    syncCycle();
    checkOutput("flush_mid_busy_t6", {31'd0, E_busy}, 32'd0);
    checkOutput("flush_mid_hi_t6", HI, 32'd0);
    checkOutput("flush_mid_lo_t6", LO, 32'd35);

    // A second mult held on the inputs while busy must not restart the unit.
    applyStimulus(OP_MULT, 32'd6, 32'd7, 1'b0);
    syncCycle();
    applyStimulus(OP_MULT, 32'd100, 32'd100, 1'b0);
    #1 checkOutput("overlap_start", {31'd0, E_start}, 32'd0);
    countBusy(n);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    checkOutput("overlap_busy_len", n, 5);
    checkOutput("overlap_hi", HI, 32'd0);
    checkOutput("overlap_lo", LO, 32'd42);

    // Reset in the middle of a divide aborts it with no late HI/LO write.
    applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0);
    syncCycle();
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    syncCycle();
    syncCycle();
    reset = 1'b1;
    syncCycle();
    reset = 1'b0;
    checkOutput("rst_mid_busy", {31'd0, E_busy}, 32'd0);
    checkOutput("rst_mid_hi", HI, 32'd0);
    checkOutput("rst_mid_lo", LO, 32'd0);
    for (int k = 0; k < 12; k++) syncCycle();
    checkOutput("rst_mid_busy_late", {31'd0, E_busy}, 32'd0);
    checkOutput("rst_mid_hi_late", HI, 32'd0);
    checkOutput("rst_mid_lo_late", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
